// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: the FSM state set and the
// FIFO geometry used by the receiver and its byte buffer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int FIFO_DEPTH = 8;
    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Reading the head is combinational, and a
// push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap explicitly so a non-power-of-two depth still behaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tb_uart_rx.sv
// UART 8N1 receiver: synchronizes the line, decodes frames with a
// mid-bit sampling FSM and queues good bytes in an 8-entry FIFO.
module tb_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            count,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  clear_err
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

    rx_state_t             state;
    logic [15:0]           cnt;
    logic [2:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx_meta;
    logic                  rx_sync;
    logic                  tick;
    logic                  stop_tick;
    logic                  good_stop;
    logic                  bad_stop;
    logic                  pop;
    logic                  fifo_full;
    logic                  drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // START samples mid-bit; DATA and STOP then land one bit period apart.
    always_comb begin
        tick = 1'b0;
        case (state)
            START:      tick = (cnt == HALF_LAST);
            DATA, STOP: tick = (cnt == FULL_LAST);
            default:    tick = 1'b0;
        endcase
    end

    assign stop_tick = (state == STOP) && tick;
    assign good_stop = stop_tick && rx_sync;
    assign bad_stop  = stop_tick && !rx_sync;
    assign pop       = out_valid && out_ready;
    assign drop      = good_stop && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A new error event outranks a simultaneous clear.
            if (bad_stop) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (good_stop),
        .pop   (pop),
        .wdata (shreg),
        .rdata (out_data),
        .valid (out_valid),
        .full  (fifo_full),
        .count (count)
    );

endmodule

// File: tb/tb_tb_uart_rx.sv
// Self-checking bench for the UART receiver: a queue-based model of the byte
// stream and sticky flags is compared against the DUT on every cycle.
module tb_tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;
    logic       clear_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0] mq[$];
    bit         m_ferr;
    bit         m_ovr;
    bit         m_pop;
    bit         m_full;
    bit         push_pending = 1'b0;
    bit         push_stop;
    logic [7:0] push_byte;

    tb_uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame completes 155 cycles after its start edge (2-cycle sync,
    // idle detect, half bit, eight data bits, stop bit); pops happen on ready.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            m_pop  = out_ready && (mq.size() != 0);
            m_full = (mq.size() == 8);
            if (clear_err) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (m_pop) void'(mq.pop_front());
            if (push_pending) begin
                if (!push_stop) m_ferr = 1'b1;
                else if (m_full && !m_pop) m_ovr = 1'b1;
                else mq.push_back(push_byte);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("valid", out_valid, mq.size() != 0);
            checkOutput("count", count, mq.size());
            if (mq.size() != 0) checkOutput("data", out_data, mq[0]);
            checkOutput("frame_err", frame_err, m_ferr);
            checkOutput("overrun", overrun, m_ovr);
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Sends one 8N1 frame; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit pop_at_stop,
                                 input bit rand_ready);
        logic [9:0] frm;
        frm = {stop_ok, b, 1'b0};
        rx = 1'b0;
        for (int cyc = 1; cyc <= 160; cyc++) begin
            tick1();
            push_byte    = b;
            push_stop    = stop_ok;
            push_pending = (cyc == 154);
            rx = (cyc < 160) ? frm[cyc/16] : 1'b1;
            if (pop_at_stop) out_ready = (cyc == 154);
            else if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
                clear_err = ($urandom_range(0, 15) == 0);
            end
        end
        push_pending = 1'b0;
    endtask

    task automatic idleCycles(input int n, input bit rand_ready);
        for (int i = 0; i < n; i++) begin
            tick1();
            if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
                clear_err = ($urandom_range(0, 15) == 0);
            end
        end
        out_ready = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        tick1();
        out_ready = 1'b0;
    endtask

    task automatic clearFlags();
        clear_err = 1'b1;
        tick1();
        clear_err = 1'b0;
        tick1();
    endtask

    initial begin
        logic [7:0] exp_order[8];
        rx = 1'b1; out_ready = 1'b0; clear_err = 1'b0; rst_n = 1'b0;
        repeat (3) tick1();
        rst_n = 1'b1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_flags", {frame_err, overrun}, 0);
        chk_en = 1'b1;
        idleCycles(5, 0);

        applyStimulus(8'h41, 1, 0, 0);
        checkOutput("byte41_data", out_data, 8'h41);
        checkOutput("byte41_valid", out_valid, 1);
        checkOutput("byte41_flags", {frame_err, overrun}, 0);
        popOne();
        idleCycles(5, 0);

        rx = 1'b0;
        repeat (4) tick1();
        rx = 1'b1;
        idleCycles(20, 0);
        checkOutput("glitch_state", dut.state, IDLE);
        checkOutput("glitch_count", count, 0);
        checkOutput("glitch_ferr", frame_err, 0);

        applyStimulus(8'h55, 0, 0, 0);
        idleCycles(10, 0);
        applyStimulus(8'h00, 1, 0, 0);
        idleCycles(3, 0);
        checkOutput("ferr_set", frame_err, 1);
        checkOutput("ferr_count", count, 1);
        checkOutput("ferr_data", out_data, 8'h00);
        popOne();
        clearFlags();
        checkOutput("ferr_clear", frame_err, 0);

        for (int i = 1; i <= 9; i++) begin
            applyStimulus(8'(i), 1, 0, 0);
            idleCycles(4, 0);
        end
        checkOutput("ovr_count", count, 8);
        checkOutput("ovr_set", overrun, 1);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("ovr_drain", out_data, i);
            popOne();
        end
        checkOutput("ovr_empty", count, 0);
        clearFlags();
        checkOutput("ovr_clear", overrun, 0);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i), 1, 0, 0);
            idleCycles(3, 0);
        end
        applyStimulus(8'h0A, 1, 1, 0);
        idleCycles(3, 0);
        checkOutput("fullpp_count", count, 8);
        checkOutput("fullpp_ovr", overrun, 0);
        exp_order = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        for (int i = 0; i < 8; i++) begin
            checkOutput("fullpp_drain", out_data, exp_order[i]);
            popOne();
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 0, 1);
            idleCycles($urandom_range(2, 30), 1);
        end
        clearFlags();

        applyStimulus(8'h77, 1, 0, 0);
        idleCycles(3, 0);
        applyStimulus(8'h12, 0, 0, 0);
        idleCycles(5, 0);
        begin
            logic [9:0] frm;
            frm = {1'b1, 8'hA5, 1'b0};
            rx = 1'b0;
            for (int cyc = 1; cyc <= 70; cyc++) begin
                tick1();
                rx = frm[cyc/16];
            end
            rst_n = 1'b0;
            tick1();
            rst_n = 1'b1;
            rx    = 1'b1;
        end
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_data", out_data, 0);
        checkOutput("midrst_flags", {frame_err, overrun}, 0);
        idleCycles(20, 0);
        applyStimulus(8'h3C, 1, 0, 0);
        idleCycles(3, 0);
        checkOutput("midrst_count2", count, 1);
        checkOutput("midrst_byte", out_data, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_uart_rx.md
TB_UART_RX -- requirements
Module: tb_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per UART bit period; legal range 4..65535, even values only.
REQ-002 SHALL have port clk, input, 1: the single clock for all state.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port rx, input, 1: serial line from riscv_top Tx; idle high; asynchronous to clk.
REQ-005 SHALL have port out_data, output, 8: byte at the FIFO head.
REQ-006 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts the head byte.
REQ-008 SHALL have port count, output, 4: FIFO occupancy, range 0..8.
REQ-009 SHALL have port frame_err, output, 1: sticky flag, set on stop bit sampled 0.
REQ-010 SHALL have port overrun, output, 1: sticky flag, set when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port clear_err, input, 1: clears frame_err and overrun.

Function
REQ-012 SHALL pass rx through a 2-FF synchronizer; all decisions use the synced value (2-cycle input latency).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, with a bit-period counter and a 3-bit bit index.
REQ-014 IDLE: synced rx=0 -> START; counter cleared.
REQ-015 START: sample at CLKS_PER_BIT/2 cycles. Sample 1 -> IDLE (glitch: no byte, no error). Sample 0 -> DATA, counter cleared.
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register; after bit 7 -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles.
- Sample 1, FIFO not full -> push byte, go IDLE.
- Sample 1, FIFO full -> drop byte, set overrun, go IDLE.
- Sample 0 -> set frame_err, discard byte, go BREAK.
REQ-018 BREAK: remain until synced rx=1, then -> IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-019 SHALL buffer bytes in an 8-entry FIFO with circular pointers that wrap 7->0; a pop occurs when out_valid & out_ready.
REQ-020 A pushed byte SHALL appear on out_data/out_valid the cycle after the stop-bit sample.
REQ-021 Push and pop in the same cycle when full: push accepted, count unchanged, no overrun.
REQ-022 Push and pop in the same cycle when empty: byte enqueued; out_valid rises next cycle.
REQ-023 out_ready while empty SHALL be ignored; count never underflows.
REQ-024 out_data is don't-care when out_valid=0.
REQ-025 clear_err clears both flags next cycle; an error event in the same cycle wins, and its flag stays/becomes 1.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE, empty FIFO (pointers and count 0), out_valid=0, out_data=0, frame_err=0, overrun=0, shift register 0, synchronizer regs 1.
REQ-027 Reset mid-frame SHALL abandon the partial byte; the next full frame after release SHALL decode correctly.

Structure
REQ-028 SHALL place the FSM state enum, the FIFO depth constant (8) and the data width (8) in the shared sim package uart_pkg.
REQ-029 SHALL instantiate one sub-module, sync_fifo, parameterised by depth and width; the FSM and synchronizer stay in tb_uart_rx.

Verification
REQ-030 With CLKS_PER_BIT=16, a frame for 0x41 -> out_data=0x41 and out_valid=1 within 166 cycles of the start edge; flags stay 0.
REQ-031 A 4-cycle low glitch on idle rx -> no push, FSM back in IDLE, count=0, frame_err=0.
REQ-032 Frame 0x55 with stop bit 0, line returned high, then good frame 0x00 -> frame_err=1, only 0x00 queued, count=1.
REQ-033 Nine frames 0x01..0x09 with out_ready=0 -> count=8, overrun=1; pops yield 0x01..0x08 in order; clear_err -> overrun=0.
REQ-034 FIFO full, out_ready=1 during the stop-bit sample of 0x0A -> count stays 8, overrun=0, 0x0A is last in the drained order.
REQ-035 rst_n=0 for 1 cycle during bit 3 of 0xA5, then frame 0x3C -> all outputs 0 after reset, only 0x3C queued.
